// File: rtl/chip_test_scheduler.sv
// ---------------------------------------------------------------------------
// chip_test_scheduler
//
// Purpose:
//   Runs one test at a time over NUM_CHIPS chip-checker FSMs that share the
//   socket and user I/O. A Start edge latches the user's chip selection. The
//   block pulses Run to that checker and waits for its Done. It captures the
//   checker's RSLT and holds the verdict for display. On user Ack it drives
//   DISP_RSLT back to the checker so that the checker returns to Halted.
//
// Parameters:
//   NUM_CHIPS       number of attached checkers (>= 2)
//   SEL_W           width of Chip_Sel (= $clog2(NUM_CHIPS))
//   TIMEOUT_CYCLES  WAIT_DONE watchdog limit. It is used only when the
//                   CHIP_TEST_TIMEOUT_EN macro is defined.
//
// Optional feature macro: CHIP_TEST_TIMEOUT_EN.
//   When it is defined, a watchdog ends WAIT_DONE with Err=1 after
//   TIMEOUT_CYCLES cycles.
//   When it is undefined, WAIT_DONE waits indefinitely and only reset
//   leaves that state.
//
// Ports:
//   Clk, Reset_n         clock and synchronous active-low reset
//   Start                user start, level; acted on at its 0->1 edge in IDLE
//   Chip_Sel [SEL_W]     checker index, sampled on the Start edge
//   Ack                  user acknowledge, sampled only in SHOW
//   Done_i/Rslt_i [N]    Done / RSLT from each checker. Only bit sel_q is used.
//   Run_o [N]            one-hot, single-cycle Run pulse to the selected checker
//   Disp_Rslt_o [N]      one-hot DISP_RSLT to the selected checker
//   Busy                 high in every state except IDLE
//   Result_Valid         the verdict is valid. It holds until the next accepted Start.
//   Pass, Err            verdict. Err means an invalid select or a timeout.
//   Pass_Cnt, Fail_Cnt   saturating 8-bit verdict counters
//   o_dbg_state          current FSM state, for observation only
//
// Handshake: Run_o and Disp_Rslt_o are level outputs decoded from the state.
//   The checker acts on them in the same cycle. Done_i is a level that the
//   checker holds until it sees DISP_RSLT, and then it drops Done_i.
// ---------------------------------------------------------------------------
module chip_test_scheduler #(
    parameter int NUM_CHIPS      = 4,
    parameter int SEL_W          = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 Start,
    input  logic [SEL_W-1:0]     Chip_Sel,
    input  logic                 Ack,
    input  logic [NUM_CHIPS-1:0] Done_i,
    input  logic [NUM_CHIPS-1:0] Rslt_i,
    output logic [NUM_CHIPS-1:0] Run_o,
    output logic [NUM_CHIPS-1:0] Disp_Rslt_o,
    output logic                 Busy,
    output logic                 Result_Valid,
    output logic                 Pass,
    output logic                 Err,
    output logic [7:0]           Pass_Cnt,
    output logic [7:0]           Fail_Cnt,
    output logic [2:0]           o_dbg_state
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RUN       = 3'd1;
    localparam logic [2:0] ST_WAIT_DONE = 3'd2;
    localparam logic [2:0] ST_SHOW      = 3'd3;
    localparam logic [2:0] ST_RELEASE   = 3'd4;

    localparam logic [NUM_CHIPS-1:0] ONE_HOT0  = {{(NUM_CHIPS-1){1'b0}}, 1'b1};
    localparam logic [SEL_W:0]       SEL_LIMIT = (SEL_W+1)'(NUM_CHIPS);

    logic [2:0]           r_state;
    logic [SEL_W-1:0]     r_sel;
    logic                 r_start_d;
    logic                 r_valid;
    logic                 r_pass;
    logic                 r_err;
    logic [7:0]           r_pass_cnt;
    logic [7:0]           r_fail_cnt;

    logic [NUM_CHIPS-1:0] w_sel_oh;
    logic                 w_start_edge;
    logic                 w_sel_bad;
    logic                 w_done;
    logic                 w_rslt;
    logic                 w_disp_on;
    logic                 w_err_to_idle;

    // If the selection is out of range, the shift gives an all-zero mask.
    // The done and result taps are then zero instead of X.
    assign w_sel_oh     = ONE_HOT0 << r_sel;
    assign w_start_edge = Start & ~r_start_d;
    assign w_sel_bad    = ({1'b0, Chip_Sel} >= SEL_LIMIT);
    assign w_done       = |(Done_i & w_sel_oh);
    assign w_rslt       = |(Rslt_i & w_sel_oh);

`ifdef CHIP_TEST_TIMEOUT_EN
    localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [TO_W-1:0] r_to_cnt;
    logic            r_timeout;

    // After a timeout the checker still gets one DISP_RSLT cycle, even
    // though Done never rose.
    assign w_disp_on     = w_done | r_timeout;
    assign w_err_to_idle = r_err & ~r_timeout;
`else
    assign w_disp_on     = w_done;
    assign w_err_to_idle = r_err;
`endif

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state    <= ST_IDLE;
            r_sel      <= '0;
            r_start_d  <= 1'b0;
            r_valid    <= 1'b0;
            r_pass     <= 1'b0;
            r_err      <= 1'b0;
            r_pass_cnt <= 8'd0;
            r_fail_cnt <= 8'd0;
`ifdef CHIP_TEST_TIMEOUT_EN
            r_to_cnt   <= '0;
            r_timeout  <= 1'b0;
`endif
        end else begin
            // Track Start in every state. A level held across a whole test
            // therefore never reads as a fresh edge back in IDLE.
            r_start_d <= Start;
            case (r_state)
                ST_IDLE: begin
                    if (w_start_edge) begin
                        r_sel   <= Chip_Sel;
                        r_valid <= 1'b0;
                        r_pass  <= 1'b0;
                        r_err   <= 1'b0;
`ifdef CHIP_TEST_TIMEOUT_EN
                        r_timeout <= 1'b0;
`endif
                        if (w_sel_bad) begin
                            r_err      <= 1'b1;
                            r_fail_cnt <= sat_inc(r_fail_cnt);
                            r_state    <= ST_SHOW;
                        end else begin
                            r_state    <= ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    r_state <= ST_WAIT_DONE;
`ifdef CHIP_TEST_TIMEOUT_EN
                    r_to_cnt <= '0;
`endif
                end
                ST_WAIT_DONE: begin
                    // Done takes priority over a timeout that lands in the same cycle.
                    if (w_done) begin
                        r_pass  <= w_rslt;
                        r_valid <= 1'b1;
                        if (w_rslt) r_pass_cnt <= sat_inc(r_pass_cnt);
                        else        r_fail_cnt <= sat_inc(r_fail_cnt);
                        r_state <= ST_SHOW;
                    end
`ifdef CHIP_TEST_TIMEOUT_EN
                    else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        r_err      <= 1'b1;
                        r_pass     <= 1'b0;
                        r_valid    <= 1'b1;
                        r_timeout  <= 1'b1;
                        r_fail_cnt <= sat_inc(r_fail_cnt);
                        r_state    <= ST_SHOW;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end
                ST_SHOW: begin
                    if (Ack) begin
                        // An invalid selection never started a checker, so
                        // there is nothing to release.
                        r_state <= w_err_to_idle ? ST_IDLE : ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
`ifdef CHIP_TEST_TIMEOUT_EN
                    if (r_timeout) r_state <= ST_IDLE;
                    else
`endif
                    if (!w_done) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign Run_o        = (r_state == ST_RUN) ? w_sel_oh : '0;
    assign Disp_Rslt_o  = ((r_state == ST_RELEASE) && w_disp_on) ? w_sel_oh : '0;
    assign Busy         = (r_state != ST_IDLE);
    assign Result_Valid = r_valid;
    assign Pass         = r_pass;
    assign Err          = r_err;
    assign Pass_Cnt     = r_pass_cnt;
    assign Fail_Cnt     = r_fail_cnt;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_chip_test_scheduler.sv
// Bench for chip_test_scheduler. Three checkers are attached, so that select
// value 3 is an invalid selection. The bench plays the role of the checker
// and of the user. Expected verdicts and counter values come from a
// transaction-level model: each completed test adds one to the pass or fail
// tally, and each tally saturates at 255.
module tb_chip_test_scheduler;
    localparam int N  = 3;
    localparam int SW = 2;
    localparam int TO = 64;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          Start = 1'b0;
    logic [SW-1:0] Chip_Sel = '0;
    logic          Ack = 1'b0;
    logic [N-1:0]  Done_i = '0;
    logic [N-1:0]  Rslt_i = '0;
    logic [N-1:0]  Run_o;
    logic [N-1:0]  Disp_Rslt_o;
    logic          Busy, Result_Valid, Pass, Err;
    logic [7:0]    Pass_Cnt, Fail_Cnt;
    logic [2:0]    o_dbg_state;

    int checks = 0;
    int errors = 0;
    int run_pulses = 0;
    int exp_pass = 0;
    int exp_fail = 0;

    chip_test_scheduler #(.NUM_CHIPS(N), .SEL_W(SW), .TIMEOUT_CYCLES(TO)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Chip_Sel(Chip_Sel), .Ack(Ack),
        .Done_i(Done_i), .Rslt_i(Rslt_i), .Run_o(Run_o), .Disp_Rslt_o(Disp_Rslt_o),
        .Busy(Busy), .Result_Valid(Result_Valid), .Pass(Pass), .Err(Err),
        .Pass_Cnt(Pass_Cnt), .Fail_Cnt(Fail_Cnt), .o_dbg_state(o_dbg_state)
    );

    always #5 Clk = ~Clk;

    // Each cycle in which Run_o is nonzero counts as one cycle of Run pulse.
    always @(negedge Clk) if (Run_o != '0) run_pulses++;

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= 255) ? 255 : v + 1;
    endfunction

    function automatic logic [N-1:0] onehot(input int sel);
        logic [N-1:0] one;
        one = 1;
        return (sel < N) ? (one << sel) : '0;
    endfunction

    // Runs one complete test. The inputs are: the select value, the checker
    // latency, the verdict, the number of cycles before Ack, the number of
    // extra cycles for which the checker holds Done during release, and
    // whether Start is toggled while the test is in progress.
    task automatic run_test(input int sel, input int lat, input bit rslt,
                            input int ack_dly, input int hold, input bit toggle);
        logic [N-1:0] oh;
        int p0;
        oh = onehot(sel);
        Start = 1'b0;
        tick();
        Chip_Sel = SW'(sel);
        Start = 1'b1;
        p0 = run_pulses;
        tick();
        if (sel >= N) begin
            exp_fail = sat(exp_fail);
            chk("bad_err", Err, 1);
            chk("bad_pass", Pass, 0);
            chk("bad_run", Run_o, 0);
            chk("bad_busy", Busy, 1);
            chk("bad_failcnt", Fail_Cnt, exp_fail);
            for (int i = 0; i < ack_dly; i++) begin
                tick();
                chk("bad_disp_show", Disp_Rslt_o, 0);
            end
            Ack = 1'b1;
            tick();
            Ack = 1'b0;
            chk("bad_idle", Busy, 0);
            chk("bad_disp", Disp_Rslt_o, 0);
            chk("bad_no_run", run_pulses - p0, 0);
            return;
        end
        chk("run_pulse", Run_o, oh);
        chk("run_busy", Busy, 1);
        chk("run_rv_clear", Result_Valid, 0);
        tick();
        chk("run_single", Run_o, 0);
        for (int i = 0; i < lat; i++) begin
            if (toggle) Start = 1'($urandom);
            Done_i = N'($urandom) & ~oh;
            Rslt_i = N'($urandom);
            tick();
            chk("wait_rv", Result_Valid, 0);
        end
        Done_i = N'($urandom) | oh;
        Rslt_i = rslt ? (N'($urandom) | oh) : (N'($urandom) & ~oh);
        tick();
        if (rslt) exp_pass = sat(exp_pass);
        else      exp_fail = sat(exp_fail);
        chk("show_rv", Result_Valid, 1);
        chk("show_pass", Pass, rslt);
        chk("show_err", Err, 0);
        chk("show_passcnt", Pass_Cnt, exp_pass);
        chk("show_failcnt", Fail_Cnt, exp_fail);
        for (int i = 0; i < ack_dly; i++) begin
            if (toggle) Start = 1'($urandom);
            Rslt_i = N'($urandom);
            tick();
            chk("show_disp", Disp_Rslt_o, 0);
            chk("show_hold_pass", Pass, rslt);
        end
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        chk("rel_disp", Disp_Rslt_o, oh);
        chk("rel_run", Run_o, 0);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("rel_hold", Disp_Rslt_o, oh);
        end
        Done_i = N'($urandom) & ~oh;
        #1;
        chk("rel_drop", Disp_Rslt_o, 0);
        tick();
        chk("end_idle", Busy, 0);
        chk("end_rv_held", Result_Valid, 1);
        chk("end_one_run", run_pulses - p0, 1);
        Done_i = '0;
    endtask

    // Issues a Start edge and leaves the DUT in its first WAIT_DONE cycle.
    task automatic start_only(input int sel);
        Done_i = '0;
        Start = 1'b0;
        tick();
        Chip_Sel = SW'(sel);
        Start = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        // Reset state.
        Reset_n = 1'b0;
        tick();
        tick();
        chk("rst_run", Run_o, 0);
        chk("rst_disp", Disp_Rslt_o, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_rv", Result_Valid, 0);
        chk("rst_cnts", {Pass_Cnt, Fail_Cnt}, 0);
        Reset_n = 1'b1;
        tick();

        // T1 pass, T2 fail, T3 invalid select.
        run_test(1, 5, 1'b1, 2, 2, 1'b0);
        run_test(2, 3, 1'b0, 0, 1, 1'b0);
        run_test(3, 0, 1'b0, 2, 0, 1'b0);

        // T5: Start is toggled during the test. Then Start is held high back in IDLE.
        run_test(0, 6, 1'b1, 4, 1, 1'b1);
        run_test(1, 4, 1'b0, 1, 0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("held_start_idle", Busy, 0);
        end

        // Randomized tests.
        for (int t = 0; t < 40; t++)
            run_test($urandom_range(0, 3), $urandom_range(0, 12), 1'($urandom),
                     $urandom_range(0, 5), $urandom_range(0, 4), 1'($urandom));

        // T4: the checker never raises Done.
`ifdef CHIP_TEST_TIMEOUT_EN
        start_only(0);
        for (int i = 0; i < TO - 1; i++) tick();
        chk("to_before", Err, 0);
        tick();
        exp_fail = sat(exp_fail);
        chk("to_err", Err, 1);
        chk("to_rv", Result_Valid, 1);
        chk("to_pass", Pass, 0);
        chk("to_failcnt", Fail_Cnt, exp_fail);
        Ack = 1'b1;
        tick();
        Ack = 1'b0;
        chk("to_disp", Disp_Rslt_o, onehot(0));
        tick();
        chk("to_disp_off", Disp_Rslt_o, 0);
        chk("to_idle", Busy, 0);
        start_only(1);
        tick();
`else
        start_only(0);
        for (int i = 0; i < 1000; i++) tick();
        chk("nto_busy", Busy, 1);
        chk("nto_rv", Result_Valid, 0);
`endif

        // T6: reset during WAIT_DONE.
        Reset_n = 1'b0;
        tick();
        Reset_n = 1'b1;
        exp_pass = 0;
        exp_fail = 0;
        chk("mid_rst_run", Run_o, 0);
        chk("mid_rst_disp", Disp_Rslt_o, 0);
        chk("mid_rst_busy", Busy, 0);
        chk("mid_rst_flags", {Result_Valid, Pass, Err}, 0);
        chk("mid_rst_cnts", {Pass_Cnt, Fail_Cnt}, 0);

        // Pass_Cnt saturates at 255.
        for (int t = 0; t < 260; t++)
            run_test($urandom_range(0, N - 1), 0, 1'b1, 0, 0, 1'b0);
        chk("sat_pass", Pass_Cnt, 255);
        chk("sat_fail", Fail_Cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
